kb_direction_rx: RTL

KB_DIRECTION_RX -- requirements
Module: kb_direction_rx

---
 rtl/kb_direction_rx_if.sv | 20 ++
 rtl/kb_direction_rx.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/kb_direction_rx_if.sv
// PS/2 keyboard line pair plus the decoded heading/code outputs of kb_direction_rx.
// master = keyboard/bench side, slave = receiver side.
interface kb_direction_rx_if;
   logic       KB_clk;
   logic       KB_data;
   logic [3:0] direction;
   logic [7:0] code;
   logic       code_valid;
   logic       frame_error;

   modport master (
      output KB_clk, KB_data,
      input  direction, code, code_valid, frame_error
   );

   modport slave (
      input  KB_clk, KB_data,
      output direction, code, code_valid, frame_error
   );
endinterface

// File: rtl/kb_direction_rx.sv
// PS/2 receiver: synchronizes and glitch-filters KB_clk, deframes 11-bit frames,
// and turns arrow/WASD make codes into a one-hot heading with optional reverse lockout.
module kb_direction_rx #(
   parameter int unsigned FILTER_LEN = 8,
   parameter int unsigned TIMEOUT    = 50000,
   parameter bit          NO_REVERSE = 1'b1
) (
   input  logic               VGA_clk,
   input  logic               reset,
   kb_direction_rx_if.slave   kb
);

   localparam int unsigned FW = $clog2(FILTER_LEN + 1);
   localparam int unsigned TW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_e;

   state_e          state_q, state_d;
   logic            kclk_s1_q, kclk_s2_q, kdat_s1_q, kdat_s2_q;
   logic            filt_q, filt_d;
   logic [FW-1:0]   fcnt_q, fcnt_d;
   logic [2:0]      bitcnt_q, bitcnt_d;
   logic [7:0]      shift_q, shift_d;
   logic            par_q, par_d;
   logic [TW-1:0]   tocnt_q, tocnt_d;
   logic            ext_q, ext_d, brk_q, brk_d;
   logic [3:0]      dir_q, dir_d;
   logic [7:0]      code_q, code_d;
   logic            cv_q, cv_d, fe_q, fe_d;
   logic            sample_c;
   logic [3:0]      dec_c, opp_c;

   function automatic logic [3:0] decode(input logic [7:0] b, input logic ext);
      logic [3:0] d;
      d = 4'b0000;
      if (!ext) begin
         case (b)
            8'h1D:   d = 4'b0001;
            8'h1C:   d = 4'b0010;
            8'h1B:   d = 4'b0100;
            8'h23:   d = 4'b1000;
            default: d = 4'b0000;
         endcase
      end else begin
         case (b)
            8'h75:   d = 4'b0001;
            8'h6B:   d = 4'b0010;
            8'h72:   d = 4'b0100;
            8'h74:   d = 4'b1000;
            default: d = 4'b0000;
         endcase
      end
      return d;
   endfunction

   assign dec_c = decode(shift_q, ext_q);
   // Rotating by two bits maps up<->down and left<->right.
   assign opp_c = {dir_q[1:0], dir_q[3:2]};

   // PS/2 lines idle high, so the synchronizers and filter reset to 1.
   always_ff @(posedge VGA_clk or posedge reset) begin
      if (reset) begin
         kclk_s1_q <= 1'b1;
         kclk_s2_q <= 1'b1;
         kdat_s1_q <= 1'b1;
         kdat_s2_q <= 1'b1;
         filt_q    <= 1'b1;
         fcnt_q    <= '0;
      end else begin
         kclk_s1_q <= kb.KB_clk;
         kclk_s2_q <= kclk_s1_q;
         kdat_s1_q <= kb.KB_data;
         kdat_s2_q <= kdat_s1_q;
         filt_q    <= filt_d;
         fcnt_q    <= fcnt_d;
      end
   end

   always_comb begin
      filt_d = filt_q;
      fcnt_d = '0;
      if (kclk_s2_q != filt_q) begin
         if (fcnt_q == FW'(FILTER_LEN - 1)) filt_d = kclk_s2_q;
         else                               fcnt_d = fcnt_q + FW'(1);
      end
   end

   assign sample_c = filt_q & ~filt_d;

   always_ff @(posedge VGA_clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         bitcnt_q <= '0;
         shift_q  <= '0;
         par_q    <= 1'b0;
         tocnt_q  <= '0;
         ext_q    <= 1'b0;
         brk_q    <= 1'b0;
         dir_q    <= '0;
         code_q   <= '0;
         cv_q     <= 1'b0;
         fe_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         bitcnt_q <= bitcnt_d;
         shift_q  <= shift_d;
         par_q    <= par_d;
         tocnt_q  <= tocnt_d;
         ext_q    <= ext_d;
         brk_q    <= brk_d;
         dir_q    <= dir_d;
         code_q   <= code_d;
         cv_q     <= cv_d;
         fe_q     <= fe_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      bitcnt_d = bitcnt_q;
      shift_d  = shift_q;
      par_d    = par_q;
      tocnt_d  = tocnt_q;
      ext_d    = ext_q;
      brk_d    = brk_q;
      dir_d    = dir_q;
      code_d   = code_q;
      cv_d     = 1'b0;
      fe_d     = 1'b0;

      case (state_q)
         IDLE: begin
            tocnt_d  = '0;
            bitcnt_d = '0;
            if (sample_c && !kdat_s2_q) state_d = DATA;
         end
         DATA: begin
            if (sample_c) begin
               shift_d  = {kdat_s2_q, shift_q[7:1]};
               bitcnt_d = bitcnt_q + 3'd1;
               if (bitcnt_q == 3'd7) state_d = PARITY;
            end
         end
         PARITY: begin
            if (sample_c) begin
               par_d   = kdat_s2_q;
               state_d = STOP;
            end
         end
         STOP: begin
            if (sample_c) begin
               state_d = IDLE;
               if (kdat_s2_q && (^{shift_q, par_q})) begin
                  cv_d   = 1'b1;
                  code_d = shift_q;
                  if (shift_q == 8'hF0) begin
                     brk_d = 1'b1;
                  end else if (shift_q == 8'hE0) begin
                     ext_d = 1'b1;
                  end else begin
                     ext_d = 1'b0;
                     brk_d = 1'b0;
                     if (!brk_q && (dec_c != 4'b0000) &&
                         !(NO_REVERSE && (dir_q != 4'b0000) && (dec_c == opp_c)))
                        dir_d = dec_c;
                  end
               end else begin
                  fe_d  = 1'b1;
                  ext_d = 1'b0;
                  brk_d = 1'b0;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // Abandon a stalled frame; stop-bit handling above never overlaps since sample_c clears the count.
      if (state_q != IDLE) begin
         if (sample_c) begin
            tocnt_d = '0;
         end else if (tocnt_q == TW'(TIMEOUT - 1)) begin
            state_d = IDLE;
            tocnt_d = '0;
            fe_d    = 1'b1;
            ext_d   = 1'b0;
            brk_d   = 1'b0;
         end else begin
            tocnt_d = tocnt_q + TW'(1);
         end
      end
   end

   assign kb.direction   = dir_q;
   assign kb.code        = code_q;
   assign kb.code_valid  = cv_q;
   assign kb.frame_error = fe_q;

endmodule
